// File: rtl/pe_col_drain.sv
// Column drain below the last PE row: accumulates K-pass partial sums, requantizes to
// signed OUT_WIDTH (round, shift, saturate) and queues results. Optional ReLU: PE_COL_DRAIN_RELU_EN.
module pe_col_drain #(
    parameter int IN_WIDTH   = 24,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int PASS_WIDTH = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_cfg_vld,
    input  logic [PASS_WIDTH-1:0]           i_cfg_num_pass,
    input  logic [4:0]                      i_cfg_shift,
    input  logic                            i_vld,
    input  logic [IN_WIDTH-1:0]             i_data,
    output logic                            o_vld,
    output logic [OUT_WIDTH-1:0]            o_data,
    input  logic                            i_rdy,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_cnt,
    output logic                            o_busy,
    output logic                            o_ovf
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int R_W   = ACC_WIDTH + 1;
    localparam logic signed [R_W-1:0] SAT_MAX = R_W'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [R_W-1:0] SAT_MIN = ~SAT_MAX;

    // configuration
    logic [PASS_WIDTH-1:0] num_pass_q, num_pass_d;
    logic [4:0]            shift_q, shift_d;

    // S0 accumulate
    logic [PASS_WIDTH-1:0]        pass_cnt_q, pass_cnt_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0]  in_ext;
    logic                         pass_last;
    logic                         s1_vld_q, s1_vld_d;

    // S1 round/shift
    logic signed [R_W-1:0] acc_ext, rnd, rsum, r_d;
    logic signed [R_W-1:0] s2_r_q;
    logic                  s2_vld_q, s2_vld_d;

    // S2 saturate, registered as the FIFO write request
    logic [OUT_WIDTH-1:0]  sat_d;
    logic [OUT_WIDTH-1:0]  wr_data_q;
    logic                  wr_vld_q, wr_vld_d;

    // result FIFO
    logic [OUT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  full, push, pop;

    assign in_ext    = ACC_WIDTH'($signed(i_data));
    assign pass_last = (pass_cnt_q == num_pass_q - PASS_WIDTH'(1));

    assign o_busy     = (pass_cnt_q != '0) | s1_vld_q | s2_vld_q;
    assign o_vld      = (cnt_q != '0);
    assign o_data     = o_vld ? mem_q[rd_ptr_q] : '0;
    assign o_fifo_cnt = cnt_q;
    assign o_ovf      = ovf_q;

    always_comb begin
        num_pass_d = num_pass_q;
        shift_d    = shift_q;
        if (i_cfg_vld && !o_busy) begin
            num_pass_d = (i_cfg_num_pass == '0) ? PASS_WIDTH'(1) : i_cfg_num_pass;
            shift_d    = i_cfg_shift;
        end
    end

    always_comb begin
        pass_cnt_d = pass_cnt_q;
        acc_d      = acc_q;
        s1_vld_d   = 1'b0;
        if (i_vld) begin
            acc_d = (pass_cnt_q == '0) ? in_ext : acc_q + in_ext;
            if (pass_last) begin
                pass_cnt_d = '0;
                s1_vld_d   = 1'b1;
            end else begin
                pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
            end
        end
    end

    // One extra bit of headroom so adding the rounding constant cannot wrap.
    always_comb begin
        acc_ext  = R_W'(acc_q);
        rnd      = '0;
        if (shift_q != '0)
            rnd = R_W'(1) << (shift_q - 5'd1);
        rsum     = acc_ext + rnd;
        r_d      = (shift_q == '0) ? acc_ext : (rsum >>> shift_q);
        s2_vld_d = s1_vld_q;
    end

    always_comb begin
`ifdef PE_COL_DRAIN_RELU_EN
        if (s2_r_q < 0)
            sat_d = '0;
        else if (s2_r_q > SAT_MAX)
            sat_d = SAT_MAX[OUT_WIDTH-1:0];
        else
            sat_d = s2_r_q[OUT_WIDTH-1:0];
`else
        if (s2_r_q > SAT_MAX)
            sat_d = SAT_MAX[OUT_WIDTH-1:0];
        else if (s2_r_q < SAT_MIN)
            sat_d = SAT_MIN[OUT_WIDTH-1:0];
        else
            sat_d = s2_r_q[OUT_WIDTH-1:0];
`endif
        wr_vld_d = s2_vld_q;
    end

    // A write into a full FIFO survives only if the head leaves in the same cycle.
    always_comb begin
        full     = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop      = o_vld & i_rdy;
        push     = wr_vld_q & (~full | pop);
        ovf_d    = ovf_q | (wr_vld_q & full & ~pop);
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_pass_q <= PASS_WIDTH'(1);
            shift_q    <= '0;
            pass_cnt_q <= '0;
            acc_q      <= '0;
            s1_vld_q   <= 1'b0;
            s2_r_q     <= '0;
            s2_vld_q   <= 1'b0;
            wr_data_q  <= '0;
            wr_vld_q   <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            num_pass_q <= num_pass_d;
            shift_q    <= shift_d;
            pass_cnt_q <= pass_cnt_d;
            acc_q      <= acc_d;
            s1_vld_q   <= s1_vld_d;
            s2_r_q     <= r_d;
            s2_vld_q   <= s2_vld_d;
            wr_data_q  <= sat_d;
            wr_vld_q   <= wr_vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: o_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem_q[wr_ptr_q] <= wr_data_q;
    end

endmodule

// File: tb/tb_pe_col_drain.sv
// Directed bench for pe_col_drain: requant math, latency, FIFO full/overflow, reset, config gating.
module tb_pe_col_drain;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_cfg_vld;
    logic [3:0]  i_cfg_num_pass;
    logic [4:0]  i_cfg_shift;
    logic        i_vld;
    logic [23:0] i_data;
    logic        o_vld;
    logic [7:0]  o_data;
    logic        i_rdy;
    logic [3:0]  o_fifo_cnt;
    logic        o_busy;
    logic        o_ovf;

    int n_vec = 0;
    int n_err = 0;

    pe_col_drain dut (
        .clk(clk), .rst(rst),
        .i_cfg_vld(i_cfg_vld), .i_cfg_num_pass(i_cfg_num_pass), .i_cfg_shift(i_cfg_shift),
        .i_vld(i_vld), .i_data(i_data),
        .o_vld(o_vld), .o_data(o_data), .i_rdy(i_rdy),
        .o_fifo_cnt(o_fifo_cnt), .o_busy(o_busy), .o_ovf(o_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [3:0] np, input logic [4:0] sh);
        i_cfg_vld = 1'b1; i_cfg_num_pass = np; i_cfg_shift = sh;
        step();
        i_cfg_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_cfg_vld = 1'b0; i_cfg_num_pass = '0; i_cfg_shift = '0;
        i_vld = 1'b0; i_data = '0; i_rdy = 1'b1;
        step(); step();
        chk("rst_vld",  32'(o_vld), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_cnt",  32'(o_fifo_cnt), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ovf",  32'(o_ovf), 32'd0);
        rst = 1'b0;
        step();

        // reset defaults: num_pass=1, shift=0; 100, 300, -300
        i_vld = 1'b1; i_data = 24'd100;
        step(); chk("lat_e0", 32'(o_vld), 32'd0);
        i_data = 24'd300;
        step(); chk("lat_e1", 32'(o_vld), 32'd0);
        i_data = -24'sd300;
        step(); chk("lat_e2", 32'(o_vld), 32'd0);
        i_vld = 1'b0;
        step(); chk("lat_e3", 32'(o_vld), 32'd1);
        chk("d100", 32'(o_data), 32'h64);
        step(); chk("d300_sat", 32'(o_data), 32'h7F);
        step();
`ifdef PE_COL_DRAIN_RELU_EN
        chk("dm300_relu", 32'(o_data), 32'h00);
`else
        chk("dm300_sat", 32'(o_data), 32'h80);
`endif
        step(); chk("t1_empty", 32'(o_vld), 32'd0);

        // num_pass=3, shift=2: 10+20-3=27 -> (27+2)>>>2 = 7; config while busy ignored
        cfg(4'd3, 5'd2);
        i_vld = 1'b1; i_data = 24'd10;
        step(); chk("busy_p1", 32'(o_busy), 32'd1);
        i_data = 24'd20; i_cfg_vld = 1'b1; i_cfg_num_pass = 4'd1; i_cfg_shift = 5'd0;
        step(); chk("busy_p2", 32'(o_busy), 32'd1);
        i_cfg_vld = 1'b0; i_data = -24'sd3;
        step(); chk("busy_s1", 32'(o_busy), 32'd1);
        i_vld = 1'b0;
        step(); chk("busy_s2", 32'(o_busy), 32'd1);
        step(); chk("acc3_nvld", 32'(o_vld), 32'd0);
        step(); chk("acc3_vld", 32'(o_vld), 32'd1);
        chk("acc3_data", 32'(o_data), 32'h07);
        chk("acc3_cnt", 32'(o_fifo_cnt), 32'd1);
        step(); chk("acc3_empty", 32'(o_vld), 32'd0);

        // num_pass=0 acts as 1; shift=4: (-40+8)>>>4 = -2
        cfg(4'd0, 5'd4);
        i_vld = 1'b1; i_data = -24'sd40;
        step(); i_vld = 1'b0;
        step(); step(); step();
`ifdef PE_COL_DRAIN_RELU_EN
        chk("rnd_neg_relu", 32'(o_data), 32'h00);
`else
        chk("rnd_neg", 32'(o_data), 32'hFE);
`endif
        step();

        // ReLU / saturation vectors, shift=0: -5, 200
        cfg(4'd1, 5'd0);
        i_vld = 1'b1; i_data = -24'sd5;
        step(); i_data = 24'd200;
        step(); i_vld = 1'b0;
        step(); step();
`ifdef PE_COL_DRAIN_RELU_EN
        chk("m5_relu", 32'(o_data), 32'h00);
`else
        chk("m5", 32'(o_data), 32'hFB);
`endif
        step(); chk("d200", 32'(o_data), 32'h7F);
        step();

        // overflow: 9 results with i_rdy=0, ninth dropped
        i_rdy = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            i_vld = 1'b1; i_data = 24'(k);
            step();
        end
        i_vld = 1'b0;
        step(); step(); step(); step();
        chk("ovf_cnt", 32'(o_fifo_cnt), 32'd8);
        chk("ovf_flag", 32'(o_ovf), 32'd1);
        i_rdy = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("drain_%0d", k), 32'(o_data), 32'(k));
            step();
        end
        chk("drain_empty", 32'(o_vld), 32'd0);
        chk("ovf_sticky", 32'(o_ovf), 32'd1);

        // full FIFO with pop in the arrival cycle: no drop
        do_reset();
        chk("rst_ovf_clr", 32'(o_ovf), 32'd0);
        i_rdy = 1'b0;
        for (int k = 11; k <= 18; k++) begin
            i_vld = 1'b1; i_data = 24'(k);
            step();
        end
        i_vld = 1'b0;
        step(); step(); step();
        chk("full_cnt", 32'(o_fifo_cnt), 32'd8);
        i_vld = 1'b1; i_data = 24'd19;
        step(); i_vld = 1'b0;
        step(); step();
        i_rdy = 1'b1;
        step(); i_rdy = 1'b0;
        chk("fullpop_cnt", 32'(o_fifo_cnt), 32'd8);
        chk("fullpop_ovf", 32'(o_ovf), 32'd0);
        i_rdy = 1'b1;
        for (int k = 12; k <= 19; k++) begin
            chk($sformatf("fdrain_%0d", k), 32'(o_data), 32'(k));
            step();
        end
        chk("fdrain_empty", 32'(o_vld), 32'd0);

        // reset mid-accumulation discards the partial sum
        cfg(4'd4, 5'd0);
        i_vld = 1'b1; i_data = 24'd100;
        step(); i_data = 24'd200;
        step(); i_vld = 1'b0;
        chk("mid_busy", 32'(o_busy), 32'd1);
        do_reset();
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        cfg(4'd1, 5'd0);
        i_vld = 1'b1; i_data = 24'd5;
        step(); i_vld = 1'b0;
        step(); step(); step();
        chk("post_rst_vld", 32'(o_vld), 32'd1);
        chk("post_rst_data", 32'(o_data), 32'h05);
        step();
        chk("post_rst_empty", 32'(o_vld), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pe_col_drain.md
Name: pe_col_drain

Overview:
- Sits directly below the last PE row, one instance per systolic column.
- Consumes the column's bottom partial-sum stream (pop_vld plus 24-bit down data).
- Accumulates partial sums over a configurable number of K-passes, then requantizes the total to signed 8-bit (round, shift, saturate).
- Buffers results in a small FIFO with a valid/ready interface toward the writeback/output SRAM.

Parameters:
- IN_WIDTH, 24, width of the signed partial sum from the PE column.
- ACC_WIDTH, 32, width of the signed accumulator (must be >= IN_WIDTH).
- OUT_WIDTH, 8, width of the signed requantized result.
- PASS_WIDTH, 4, width of the pass-count configuration.
- FIFO_DEPTH, 8, result FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_cfg_vld  in  1  configuration strobe
- i_cfg_num_pass  in  PASS_WIDTH  passes per output; 0 is treated as 1
- i_cfg_shift  in  5  right-shift amount for requantization
- i_vld  in  1  partial-sum valid (bottom PE pop_vld)
- i_data  in  IN_WIDTH  signed partial sum (bottom PE down data)
- o_vld  out  1  FIFO head valid
- o_data  out  OUT_WIDTH  FIFO head data
- i_rdy  in  1  consumer ready
- o_fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_busy  out  1  accumulation partially complete or requant pipeline occupied
- o_ovf  out  1  sticky overflow: a result was dropped

Behaviour:
- Reset (clk edge with rst=1):
  - All outputs go to 0; FIFO is emptied; pass_cnt=0; acc=0; pipeline valids are cleared.
  - Config defaults: num_pass=1, shift=0.
  - Reset mid-accumulation discards the partial sum and any in-flight results.
- Config:
  - i_cfg_vld is sampled only when o_busy=0; it latches num_pass and shift.
  - When o_busy=1, i_cfg_vld is ignored and has no effect.
- Accumulate stage (S0), on each i_vld:
  - ext = i_data sign-extended to ACC_WIDTH.
  - If pass_cnt==0: acc <= ext; else acc <= acc + ext (wraps modulo 2^ACC_WIDTH, no saturation).
  - If pass_cnt==num_pass-1: pass_cnt <= 0 and s1_vld <= 1; else pass_cnt <= pass_cnt + 1 and s1_vld <= 0.
  - The block accepts one sample per cycle and never stalls upstream (the systolic array cannot be backpressured).
- Shift stage (S1):
  - If shift>0: r = (acc + 2^(shift-1)) >>> shift (round half up, arithmetic shift).
  - If shift==0: r = acc.
  - The add is done at ACC_WIDTH+1 bits so rounding cannot overflow.
- Saturate stage (S2):
  - Clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], then write the result to the FIFO.
- Latency: the final-pass sample accepted at edge E0 appears at the FIFO head (o_vld=1) after edge E3, provided the FIFO was empty.
- FIFO:
  - o_vld = (cnt != 0); o_data = head entry, registered storage read without an added cycle.
  - Pop on o_vld && i_rdy.
- Write when full:
  - If a pop occurs in the same cycle, the write is accepted and cnt is unchanged.
  - Otherwise the result is dropped, o_ovf is set to 1, and o_ovf stays 1 until rst.
- Read and write in the same cycle on a non-full, non-empty FIFO: cnt is unchanged.
- Write to an empty FIFO: visible on o_vld the next cycle (no bypass).
- o_busy = (pass_cnt != 0) | s1_vld | s2_vld.

Optional Feature:
- Macro: PE_COL_DRAIN_RELU_EN.
- Defined: S2 clamps negative values to 0 before saturation, so the output range is [0, 2^(OUT_WIDTH-1)-1].
- Undefined: full signed saturation as specified above; no ReLU logic is instantiated.

Test Plan:
- num_pass=1, shift=0; i_data = 100, 300, -300 on consecutive cycles -> o_data = 100, 127, -128; first o_vld exactly 3 edges after the first i_vld.
- num_pass=3, shift=2; i_data = 10, 20, -3 -> single output 7 (sum 27, +2 -> 29 >>> 2); o_busy=1 from the first sample until the FIFO write.
- num_pass=1, shift=0, i_rdy=0; 9 results -> o_fifo_cnt=8, o_ovf=1, ninth value dropped. Then i_rdy=1 -> the 8 values drain in order and o_ovf stays 1.
- FIFO full, i_rdy=1 in the same cycle a result arrives -> no drop, o_ovf stays 0, o_fifo_cnt stays 8.
- num_pass=4; 2 samples, then rst; then num_pass=1 config and i_data=5 -> output 5 (old partial sum discarded). Config asserted while o_busy=1 is ignored.
- With PE_COL_DRAIN_RELU_EN defined, num_pass=1, i_data=-5 -> output 0; i_data=200 -> 127.
